sram_mem_ctrl: RTL

//  Downstream of the processor's memory port: turns one CPU access (addr, write flag,

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/tri_buffer_16.sv | 10 +
 rtl/sram_mem_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and elaboration helpers for the async-SRAM controller.
// Holds the FSM state encoding, byte-lane layout and parameter sanity checks.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ACCESS,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_DONE
   } state_t;

   localparam int unsigned LANES   = 2;
   localparam int unsigned LANE_W  = 8;
   localparam int unsigned LANE_LO = 0;
   localparam int unsigned LANE_HI = 1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Both phases need at least one cycle or the counter compare underflows.
   function automatic bit timing_ok(input int unsigned rd_wait, input int unsigned wr_pulse);
      return (rd_wait >= 1) && (wr_pulse >= 1);
   endfunction

   function automatic int unsigned wait_cnt_w(input int unsigned rd_wait, input int unsigned wr_pulse);
      return $clog2(max_u(rd_wait, wr_pulse)) + 1;
   endfunction

endpackage

// File: rtl/tri_buffer_16.sv
// 16-bit tri-state pad driver: drives pad with din while en is high, else floats it.
module tri_buffer_16 (
   input  logic        en,
   input  logic [15:0] din,
   inout  wire  [15:0] pad
);

   assign pad = en ? din : 16'hzzzz;

endmodule

// File: rtl/sram_mem_ctrl.sv
// Single-access async-SRAM controller: sequences CE/OE/WE/UB/LB and the DQ bus for one
// CPU read or write, then pulses mem_ready for one cycle with read data registered.
module sram_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RD_WAIT  = 2,
   parameter int unsigned WR_PULSE = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_be,
   input  logic [15:0]       mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic              CE_N,
   output logic              UB_N,
   output logic              LB_N,
   output logic              OE_N,
   output logic              WE_N
);

   localparam int unsigned CNT_W = wait_cnt_w(RD_WAIT, WR_PULSE);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

   if (!timing_ok(RD_WAIT, WR_PULSE) || (DATA_W != LANES * LANE_W)) begin : g_bad_param
      $error("sram_mem_ctrl: RD_WAIT/WR_PULSE must be >= 1 and DATA_W must be 16");
   end

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [1:0]        be_reg;
   logic [1:0]        be_sel;
   logic [DATA_W-1:0] wdata_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic [DATA_W-1:0] rd_lanes;
   logic              accept;
   logic              capture;

   logic ce_n_reg, ub_n_reg, lb_n_reg, oe_n_reg, we_n_reg, dq_oe_reg, ready_reg;
   logic ce_n_next, ub_n_next, lb_n_next, oe_n_next, we_n_next, dq_oe_next, ready_next;

   assign accept  = (state_reg == ST_IDLE) && mem_req;
   // Outputs are registered from the next state, so on the accept edge the live byte
   // enables must be used because be_reg is only being loaded on that same edge.
   assign be_sel  = accept ? mem_be : be_reg;
   assign capture = (state_reg == ST_RD_ACCESS) && (state_next == ST_DONE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:      if (mem_req) state_next = mem_we ? ST_WR_SETUP : ST_RD_ACCESS;
         ST_RD_ACCESS: if (cnt_reg == RD_LAST) state_next = ST_DONE;
         ST_WR_SETUP:  state_next = ST_WR_PULSE;
         ST_WR_PULSE:  if (cnt_reg == WR_LAST) state_next = ST_WR_HOLD;
         ST_WR_HOLD:   state_next = ST_DONE;
         ST_DONE:      state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_next = cnt_reg;
      if (state_next != state_reg) begin
         cnt_next = '0;
      end else if ((state_reg == ST_RD_ACCESS) || (state_reg == ST_WR_PULSE)) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // With no lanes enabled the chip stays deselected; the sequence still runs for timing.
   always_comb begin
      ce_n_next  = 1'b1;
      ub_n_next  = 1'b1;
      lb_n_next  = 1'b1;
      oe_n_next  = 1'b1;
      we_n_next  = 1'b1;
      dq_oe_next = 1'b0;
      ready_next = 1'b0;
      case (state_next)
         ST_RD_ACCESS: begin
            ce_n_next = ~|be_sel;
            ub_n_next = ~be_sel[LANE_HI];
            lb_n_next = ~be_sel[LANE_LO];
            oe_n_next = 1'b0;
         end
         ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
            ce_n_next  = ~|be_sel;
            ub_n_next  = ~be_sel[LANE_HI];
            lb_n_next  = ~be_sel[LANE_LO];
            we_n_next  = (state_next != ST_WR_PULSE);
            dq_oe_next = 1'b1;
         end
         ST_DONE:  ready_next = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ce_n_reg  <= 1'b1;
         ub_n_reg  <= 1'b1;
         lb_n_reg  <= 1'b1;
         oe_n_reg  <= 1'b1;
         we_n_reg  <= 1'b1;
         dq_oe_reg <= 1'b0;
         ready_reg <= 1'b0;
         be_reg    <= '0;
         wdata_reg <= '0;
         addr_reg  <= '0;
         rdata_reg <= '0;
      end else begin
         ce_n_reg  <= ce_n_next;
         ub_n_reg  <= ub_n_next;
         lb_n_reg  <= lb_n_next;
         oe_n_reg  <= oe_n_next;
         we_n_reg  <= we_n_next;
         dq_oe_reg <= dq_oe_next;
         ready_reg <= ready_next;
         if (accept) begin
            be_reg    <= mem_be;
            wdata_reg <= mem_wdata;
            addr_reg  <= ADDR_W'(mem_addr);
         end
         if (capture) begin
            rdata_reg <= rd_lanes;
         end
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign rd_lanes[gi*LANE_W +: LANE_W] = be_reg[gi] ? SRAM_DQ[gi*LANE_W +: LANE_W] : '0;
   end

   tri_buffer_16 u_dq_buf (
      .en  (dq_oe_reg),
      .din (wdata_reg),
      .pad (SRAM_DQ)
   );

   assign mem_rdata = rdata_reg;
   assign mem_ready = ready_reg;
   assign SRAM_ADDR = addr_reg;
   assign CE_N      = ce_n_reg;
   assign UB_N      = ub_n_reg;
   assign LB_N      = lb_n_reg;
   assign OE_N      = oe_n_reg;
   assign WE_N      = we_n_reg;

endmodule
